// File: rtl/blackjack_pkg.sv
// Shared FSM encoding and blackjack scoring constants for the card controller.
package blackjack_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    LER,
    CAPTURA,
    SOMA,
    ACK
  } estado_t;

  localparam logic [5:0] LIMITE       = 6'd21;
  localparam logic [3:0] VALOR_AS     = 4'd11;
  localparam logic [3:0] AJUSTE_AS    = 4'd10;
  localparam logic [3:0] VALOR_FIGURA = 4'd10;
  localparam logic       DEST_JOGADOR = 1'b0;
  localparam logic       DEST_DEALER  = 1'b1;

endpackage

// File: rtl/valor_carta.sv
// Combinational rank-to-points conversion; flags aces and out-of-range ranks.
module valor_carta
  import blackjack_pkg::*;
(
  input  logic [3:0] carta,
  output logic [3:0] valor,
  output logic       eh_as,
  output logic       invalida
);

  always_comb begin
    valor    = 4'd0;
    eh_as    = 1'b0;
    invalida = 1'b0;
    if (carta == 4'd1) begin
      valor = VALOR_AS;
      eh_as = 1'b1;
    end else if (carta >= 4'd11 && carta <= 4'd13) begin
      valor = VALOR_FIGURA;
    end else if (carta >= 4'd2 && carta <= 4'd10) begin
      valor = carta;
    end else begin
      invalida = 1'b1;
    end
  end

endmodule

// File: rtl/controlador_cartas.sv
// Arbitrates player/dealer card requests over the shuffled deck memory and
// keeps both blackjack hand scores, acknowledging each card with cartaok.
module controlador_cartas
  import blackjack_pkg::*;
#(
  parameter int N_CARTAS = 52,
  parameter int ADDR_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              embaralhar_ok,
  input  logic              novo_jogo,
  input  logic              pjogador,
  input  logic              pdealer,
  input  logic [3:0]        mem_dado,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              cartaok,
  output logic [5:0]        pts_jogador,
  output logic [5:0]        pts_dealer,
  output logic [3:0]        ultima_carta,
  output logic              ultimo_destino,
  output logic              baralho_vazio,
  output logic              erro_carta
);

  // Pointer carries one extra bit so it can reach N_CARTAS even when 2^ADDR_W == N_CARTAS.
  localparam logic [ADDR_W:0] FIM = (ADDR_W+1)'(N_CARTAS);
  localparam logic [ADDR_W:0] UM  = (ADDR_W+1)'(1);

  estado_t         estado, prox;
  logic [ADDR_W:0] ponteiro;
  logic            destino;
  logic            prio_dealer;
  logic [2:0]      moles_jog, moles_dea;

  logic            conceder, dest_conc, req_ativo;
  logic [3:0]      valor;
  logic            eh_as, invalida;
  logic [5:0]      pts_sel, pts_novo;
  logic [2:0]      moles_sel, moles_novo;

  // Adds a card value and demotes one soft ace from 11 to 1 if the hand busts.
  function automatic logic [8:0] acumula(input logic [5:0] pts, input logic [3:0] v,
                                         input logic [2:0] moles);
    logic [5:0] s;
    logic [2:0] m;
    s = pts + {2'b00, v};
    m = moles;
    if (s > LIMITE && m != 3'd0) begin
      s = s - {2'b00, AJUSTE_AS};
      m = m - 3'd1;
    end
    return {m, s};
  endfunction

  valor_carta u_valor (
    .carta    (ultima_carta),
    .valor    (valor),
    .eh_as    (eh_as),
    .invalida (invalida)
  );

  assign baralho_vazio = (ponteiro == FIM);
  assign req_ativo     = (destino == DEST_DEALER) ? pdealer : pjogador;

  always_comb begin
    prox      = estado;
    conceder  = 1'b0;
    dest_conc = DEST_JOGADOR;
    case (estado)
      OCIOSO: begin
        if (embaralhar_ok && !baralho_vazio && (pjogador || pdealer)) begin
          conceder  = 1'b1;
          dest_conc = (pdealer && (!pjogador || prio_dealer)) ? DEST_DEALER : DEST_JOGADOR;
          prox      = LER;
        end
      end
      LER:     prox = CAPTURA;
      CAPTURA: prox = SOMA;
      SOMA:    prox = ACK;
      ACK:     if (!req_ativo) prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
    if (novo_jogo) begin
      prox     = OCIOSO;
      conceder = 1'b0;
    end
  end

  always_comb begin
    pts_sel   = (destino == DEST_DEALER) ? pts_dealer : pts_jogador;
    moles_sel = ((destino == DEST_DEALER) ? moles_dea : moles_jog) + {2'b00, eh_as};
    {moles_novo, pts_novo} = acumula(pts_sel, valor, moles_sel);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      ponteiro       <= '0;
      destino        <= DEST_JOGADOR;
      prio_dealer    <= 1'b0;
      moles_jog      <= 3'd0;
      moles_dea      <= 3'd0;
      mem_addr       <= '0;
      cartaok        <= 1'b0;
      pts_jogador    <= 6'd0;
      pts_dealer     <= 6'd0;
      ultima_carta   <= 4'd0;
      ultimo_destino <= 1'b0;
      erro_carta     <= 1'b0;
    end else begin
      estado <= prox;
      if (conceder) begin
        destino     <= dest_conc;
        mem_addr    <= ponteiro[ADDR_W-1:0];
        prio_dealer <= ~dest_conc;
      end
      case (estado)
        OCIOSO: if (!embaralhar_ok) ponteiro <= '0;
        CAPTURA: begin
          if (!novo_jogo) begin
            ultima_carta   <= mem_dado;
            ultimo_destino <= destino;
            ponteiro       <= ponteiro + UM;
          end
        end
        SOMA: begin
          if (destino == DEST_DEALER) begin
            pts_dealer <= pts_novo;
            moles_dea  <= moles_novo;
          end else begin
            pts_jogador <= pts_novo;
            moles_jog   <= moles_novo;
          end
          if (invalida) erro_carta <= 1'b1;
          cartaok <= 1'b1;
        end
        ACK: if (!req_ativo) cartaok <= 1'b0;
        default: ;
      endcase
      // A new game overrides any score write or acknowledge in the same cycle.
      if (novo_jogo) begin
        pts_jogador <= 6'd0;
        pts_dealer  <= 6'd0;
        moles_jog   <= 3'd0;
        moles_dea   <= 3'd0;
        erro_carta  <= 1'b0;
        cartaok     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_controlador_cartas.sv
// Directed bench for controlador_cartas with a 4-card deck and a synchronous deck memory model.
module tb_controlador_cartas;

  logic       clock = 1'b0;
  logic       reset, embaralhar_ok, novo_jogo, pjogador, pdealer;
  logic [3:0] mem_dado = 4'd0;
  logic [5:0] mem_addr;
  logic       cartaok, ultimo_destino, baralho_vazio, erro_carta;
  logic [5:0] pts_jogador, pts_dealer;
  logic [3:0] ultima_carta;
  logic [3:0] deck [0:63];

  int vetores = 0;
  int falhas  = 0;

  controlador_cartas #(.N_CARTAS(4), .ADDR_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .embaralhar_ok  (embaralhar_ok),
    .novo_jogo      (novo_jogo),
    .pjogador       (pjogador),
    .pdealer        (pdealer),
    .mem_dado       (mem_dado),
    .mem_addr       (mem_addr),
    .cartaok        (cartaok),
    .pts_jogador    (pts_jogador),
    .pts_dealer     (pts_dealer),
    .ultima_carta   (ultima_carta),
    .ultimo_destino (ultimo_destino),
    .baralho_vazio  (baralho_vazio),
    .erro_carta     (erro_carta)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_dado <= deck[mem_addr];

  task automatic verifica(input string tag, input int obs, input int esp);
    vetores++;
    if (obs != esp) begin
      falhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic espera_ok(input logic nivel, input int limite, output int n);
    n = 0;
    while (cartaok !== nivel && n < limite) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic reembaralha(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic [3:0] c3);
    embaralhar_ok = 1'b0;
    deck[0] = c0; deck[1] = c1; deck[2] = c2; deck[3] = c3;
    @(posedge clock); #1;
    embaralhar_ok = 1'b1;
  endtask

  task automatic pulso_novo();
    novo_jogo = 1'b1;
    @(posedge clock); #1;
    novo_jogo = 1'b0;
  endtask

  task automatic pede(input logic dealer, input string tag);
    int n;
    if (dealer) pdealer = 1'b1; else pjogador = 1'b1;
    espera_ok(1'b1, 12, n);
    verifica({tag, "_lat"}, n, 4);
  endtask

  task automatic solta(input logic dealer, input string tag);
    int n;
    if (dealer) pdealer = 1'b0; else pjogador = 1'b0;
    espera_ok(1'b0, 6, n);
    verifica({tag, "_queda"}, n, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) deck[i] = 4'd0;
    reset = 1'b1; embaralhar_ok = 1'b0; novo_jogo = 1'b0;
    pjogador = 1'b0; pdealer = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    verifica("rst_cartaok", cartaok, 0);
    verifica("rst_pts_j", pts_jogador, 0);
    verifica("rst_pts_d", pts_dealer, 0);
    verifica("rst_addr", mem_addr, 0);
    verifica("rst_vazio", baralho_vazio, 0);
    verifica("rst_erro", erro_carta, 0);

    // Simultaneous requests out of reset: player first, then dealer.
    reembaralha(4'd7, 4'd8, 4'd2, 4'd2);
    pjogador = 1'b1; pdealer = 1'b1;
    espera_ok(1'b1, 12, n);
    verifica("rr_lat_j", n, 4);
    verifica("rr_dest_j", ultimo_destino, 0);
    verifica("rr_pts_j", pts_jogador, 7);
    verifica("rr_pts_d_parado", pts_dealer, 0);
    solta(1'b0, "rr_j");
    espera_ok(1'b1, 12, n);
    verifica("rr_lat_d", n, 4);
    verifica("rr_dest_d", ultimo_destino, 1);
    verifica("rr_pts_d", pts_dealer, 8);
    verifica("rr_pts_j_parado", pts_jogador, 7);
    verifica("rr_addr_d", mem_addr, 1);
    solta(1'b1, "rr_d");

    // Player only: 10 then 5.
    pulso_novo();
    reembaralha(4'd10, 4'd5, 4'd2, 4'd2);
    pede(1'b0, "p1");
    verifica("p1_pts", pts_jogador, 10);
    verifica("p1_addr", mem_addr, 0);
    solta(1'b0, "p1");
    pede(1'b0, "p2");
    verifica("p2_pts", pts_jogador, 15);
    verifica("p2_addr", mem_addr, 1);
    verifica("p2_carta", ultima_carta, 5);
    solta(1'b0, "p2");

    // Soft aces: A, A, 9, 5 -> 11, 12, 21, 16; then deck end.
    pulso_novo();
    reembaralha(4'd1, 4'd1, 4'd9, 4'd5);
    pede(1'b0, "as1"); verifica("as1_pts", pts_jogador, 11); solta(1'b0, "as1");
    pede(1'b0, "as2"); verifica("as2_pts", pts_jogador, 12); solta(1'b0, "as2");
    pede(1'b0, "as3"); verifica("as3_pts", pts_jogador, 21); solta(1'b0, "as3");
    pede(1'b0, "as4"); verifica("as4_pts", pts_jogador, 16); solta(1'b0, "as4");
    verifica("as_moles", dut.moles_jog, 0);
    verifica("fim_vazio", baralho_vazio, 1);
    pjogador = 1'b1;
    espera_ok(1'b1, 8, n);
    verifica("fim_sem_ok", n, 8);
    verifica("fim_cartaok", cartaok, 0);
    embaralhar_ok = 1'b0;
    deck[0] = 4'd2;
    @(posedge clock); #1;
    embaralhar_ok = 1'b1;
    verifica("fim_vazio_limpo", baralho_vazio, 0);
    espera_ok(1'b1, 12, n);
    verifica("fim_lat", n, 4);
    verifica("fim_addr", mem_addr, 0);
    verifica("fim_pts", pts_jogador, 18);
    solta(1'b0, "fim");

    // novo_jogo while in LER: transaction dropped, card not consumed.
    reembaralha(4'd3, 4'd4, 4'd15, 4'd2);
    pjogador = 1'b1;
    @(posedge clock); #1;
    novo_jogo = 1'b1; pjogador = 1'b0;
    @(posedge clock); #1;
    novo_jogo = 1'b0;
    espera_ok(1'b1, 5, n);
    verifica("ler_sem_ok", n, 5);
    verifica("ler_pts_j", pts_jogador, 0);
    verifica("ler_pts_d", pts_dealer, 0);
    pede(1'b0, "ler_prox");
    verifica("ler_prox_addr", mem_addr, 0);
    verifica("ler_prox_pts", pts_jogador, 3);
    solta(1'b0, "ler_prox");

    // novo_jogo while in SOMA: card consumed, scores cleared.
    reembaralha(4'd3, 4'd4, 4'd15, 4'd2);
    pdealer = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    novo_jogo = 1'b1; pdealer = 1'b0;
    @(posedge clock); #1;
    novo_jogo = 1'b0;
    verifica("soma_cartaok", cartaok, 0);
    verifica("soma_pts_j", pts_jogador, 0);
    verifica("soma_pts_d", pts_dealer, 0);
    pede(1'b0, "soma_prox");
    verifica("soma_prox_addr", mem_addr, 1);
    verifica("soma_prox_pts", pts_jogador, 4);
    solta(1'b0, "soma_prox");

    // Invalid rank 15: sticky error, score unchanged, handshake completes.
    pede(1'b0, "inv");
    verifica("inv_erro", erro_carta, 1);
    verifica("inv_pts", pts_jogador, 4);
    verifica("inv_carta", ultima_carta, 15);
    solta(1'b0, "inv");
    verifica("inv_erro_mantido", erro_carta, 1);
    pulso_novo();
    verifica("inv_erro_limpo", erro_carta, 0);
    verifica("inv_pts_limpo", pts_jogador, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
    $finish;
  end

endmodule

// File: doc/controlador_cartas.md
Name: controlador_cartas

Overview:
- Serves card requests from the blackjack game FSM for the player and the dealer.
- Arbitrates the shared, already-shuffled deck memory between the two requesters and reads the next card.
- Converts the card rank to blackjack points, with soft-ace handling, and keeps the running score of each hand.
- Completes each request with a four-phase cartaok handshake; pts_jogador and pts_dealer are already updated when cartaok rises.

Parameters:
- N_CARTAS, 52: number of cards in the deck memory.
- ADDR_W, 6: deck memory address width; must satisfy 2^ADDR_W >= N_CARTAS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- embaralhar_ok  in  1  high = deck memory filled and shuffled; low = shuffler owns the memory.
- novo_jogo  in  1  one-cycle pulse; clears both hands.
- pjogador  in  1  player card request, level.
- pdealer  in  1  dealer card request, level.
- mem_dado  in  4  card rank (1..13) from the synchronous deck memory, valid 1 cycle after mem_addr.
- mem_addr  out  ADDR_W  deck memory read address, registered.
- cartaok  out  1  handshake acknowledge, registered.
- pts_jogador  out  6  player score.
- pts_dealer  out  6  dealer score.
- ultima_carta  out  4  rank of the last card dealt.
- ultimo_destino  out  1  destination of the last card: 0 = player, 1 = dealer.
- baralho_vazio  out  1  deck pointer == N_CARTAS.
- erro_carta  out  1  sticky; an invalid rank was read.

Behaviour:
- Reset:
  - All outputs are 0 and the deck pointer is 0.
  - Soft-ace counters are 0, the state is OCIOSO and round-robin priority is player.
- OCIOSO (idle):
  - While embaralhar_ok=0, the pointer is held at 0 and no request is granted.
  - A grant requires embaralhar_ok=1, baralho_vazio=0 and at least one request high.
  - Only one requester high: that requester is granted.
  - Both high: round-robin; the requester not served last wins, and player wins after reset.
  - On the grant edge: latch the destination, mem_addr<=pointer, go to LER.
- LER (read): wait one cycle for the memory; go to CAPTURA.
- CAPTURA (capture):
  - ultima_carta<=mem_dado, ultimo_destino<=destination.
  - pointer<=pointer+1; go to SOMA.
- SOMA (score update):
  - Card value v:
    - rank 1: v=11 and the hand's soft count +1.
    - rank 11..13: v=10.
    - rank 2..10: v=rank.
    - rank 0, 14 or 15: v=0 and erro_carta<=1.
  - Compute s=pts+v. If s>21 and soft count>0 (including an ace just added), then s-=10 and soft count -=1. At most one adjustment per card.
  - Write s to the destination hand only.
  - cartaok<=1 at the same edge; go to ACK.
- Latency: a request sampled at edge k gives mem_addr at k, updated pts and cartaok=1 at edge k+3.
- ACK:
  - cartaok is held at 1 while the granted request is high.
  - When the granted request is low: cartaok<=0 and go to OCIOSO.
  - The earliest next grant is the edge after cartaok falls.
  - The other requester is ignored during ACK.
  - If the requester drops before ACK is reached, the transaction still completes and cartaok is high for exactly 1 cycle.
- Width: a hand's maximum reachable score is 30 (20 hard + 10), so 6-bit scores never wrap. Soft counters are 3 bits.
- Deck end:
  - After the card at address N_CARTAS-1 is captured, baralho_vazio=1 and further requests stay pending with no cartaok.
  - When embaralhar_ok goes low, the pointer returns to 0 and baralho_vazio clears.
- novo_jogo:
  - Clears both scores, both soft counts and erro_carta. The pointer and round-robin priority are unchanged.
  - Mid-transaction: return to OCIOSO with cartaok=0. The card is discarded; it stays consumed if CAPTURA has already occurred.
  - novo_jogo has priority over the SOMA write in the same cycle.
- embaralhar_ok falling mid-transaction: the transaction completes normally; the pointer clear takes effect in OCIOSO.

Decomposition:
- blackjack_pkg: state encoding (OCIOSO, LER, CAPTURA, SOMA, ACK) and constants LIMITE=21, VALOR_AS=11, AJUSTE_AS=10, VALOR_FIGURA=10, DEST_JOGADOR=0, DEST_DEALER=1.
- Sub-module valor_carta: combinational rank -> {v[3:0], eh_as, invalida}. It is instantiated once, and the accumulate/adjust logic stays in the parent.

Test Plan:
- Player request only; deck holds 10, 5 -> cartaok rises 3 edges after the grant; pts_jogador=10, then after a second request 15; mem_addr 0 then 1.
- Player draws A, A, 9 -> pts_jogador 11, 12, 21; player soft count ends at 0.
- pjogador and pdealer rise in the same cycle from reset -> player served first, dealer second; pts_dealer is unchanged during the player transaction.
- N_CARTAS=4 with 5 requests -> the 5th gets no cartaok and baralho_vazio=1; drop embaralhar_ok for 1 cycle then raise it -> the 5th request is served from address 0.
- novo_jogo pulsed in the cycle after the grant (state LER) -> cartaok stays 0, both scores 0, next grant reads address 0; a pulse instead during SOMA -> both scores 0, next grant reads address 1.
- mem_dado=15 -> erro_carta=1, score unchanged, cartaok completes; novo_jogo -> erro_carta=0.
